// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix multiplier result path.
package matmul_pkg;

  localparam int DW = 32;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ACK     = 2'd1,
    FULL    = 2'd2
  } coll_state_e;

endpackage

// File: rtl/entry_scoreboard.sv
// Tracks which of the N*N result entries have arrived and how many are present.
module entry_scoreboard
  import matmul_pkg::*;
#(
  parameter int  N  = 4,
  parameter int  IW = idx_w(N),
  localparam int CW = $clog2(N*N+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set,
  input  logic [IW-1:0] i,
  input  logic [IW-1:0] j,
  input  logic          clear,
  output logic          hit,
  output logic [CW-1:0] count,
  output logic          complete
);

  logic [N-1:0][N-1:0] valid;
  logic                in_range;

  assign in_range = (int'(i) < N) && (int'(j) < N);
  // Out-of-range indices never alias a real entry.
  assign hit      = in_range && valid[i][j];
  assign complete = (count == CW'(N*N));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      count <= '0;
    end else if (clear) begin
      valid <= '0;
      count <= '0;
    end else if (set && in_range && !hit) begin
      valid[i][j] <= 1'b1;
      count       <= count + CW'(1);
    end
  end

endmodule

// File: rtl/matrix_result_collector.sv
// Collects (z_in, z_i, z_j) words over a stb/ack handshake into an N x N buffer
// and exposes it through a registered random-access read port.
module matrix_result_collector
  import matmul_pkg::*;
#(
  parameter int  N  = 4,
  parameter int  DW = matmul_pkg::DW,
  parameter int  IW = idx_w(N),
  localparam int CW = $clog2(N*N+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic [DW-1:0] z_in,
  input  logic [IW-1:0] z_i,
  input  logic [IW-1:0] z_j,
  input  logic          z_stb,
  output logic          z_ack,
  input  logic          rd_en,
  input  logic [IW-1:0] rd_i,
  input  logic [IW-1:0] rd_j,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic [CW-1:0] count,
  output logic          complete,
  output logic          dup_err
);

  coll_state_e   state;
  logic [DW-1:0] mem [N][N];
  logic          accept, hit, wr_in_range, rd_in_range;

  assign wr_in_range = (int'(z_i) < N) && (int'(z_j) < N);
  assign rd_in_range = (int'(rd_i) < N) && (int'(rd_j) < N);
  // The strobe still high during ACK belongs to the word just taken.
  assign accept      = z_stb && !clear && (state != ACK);

  entry_scoreboard #(.N(N), .IW(IW)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set      (accept),
    .i        (z_i),
    .j        (z_j),
    .clear    (clear),
    .hit      (hit),
    .count    (count),
    .complete (complete)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= COLLECT;
      z_ack   <= 1'b0;
      dup_err <= 1'b0;
    end else begin
      z_ack <= 1'b0;
      if (clear) begin
        state   <= COLLECT;
        dup_err <= 1'b0;
      end else begin
        case (state)
          ACK:     state <= complete ? FULL : COLLECT;
          default: if (z_stb) begin
            state <= ACK;
            z_ack <= 1'b1;
            if (hit || !wr_in_range) dup_err <= 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && wr_in_range) mem[z_i][z_j] <= z_in;
  end

  // Non-blocking write means a same-edge read sees the previous contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_in_range ? mem[rd_i][rd_j] : '0;
    end
  end

endmodule

// File: tb/tb_matrix_result_collector.sv
// Self-checking bench for matrix_result_collector: directed table, corner sequences, random traffic.
module tb_matrix_result_collector;
  import matmul_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int CW = 5;

  logic          clk = 0, rst = 0, clear = 0, z_stb = 0, rd_en = 0;
  logic [31:0]   z_in = '0;
  logic [IW-1:0] z_i = '0, z_j = '0, rd_i = '0, rd_j = '0;
  logic          z_ack, rd_valid, complete, dup_err;
  logic [31:0]   rd_data;
  logic [CW-1:0] count;

  matrix_result_collector #(.N(N)) dut (
    .clk(clk), .rst(rst), .clear(clear), .z_in(z_in), .z_i(z_i), .z_j(z_j),
    .z_stb(z_stb), .z_ack(z_ack), .rd_en(rd_en), .rd_i(rd_i), .rd_j(rd_j),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .complete(complete), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;

  // Reference model: what the buffer holds, which entries are present, sticky error.
  logic [31:0] m_mem [N][N];
  bit          m_val [N][N];
  bit          m_dup;

  function automatic int m_count();
    int c = 0;
    for (int a = 0; a < N; a++) for (int b = 0; b < N; b++) c += m_val[a][b];
    return c;
  endfunction

  function automatic void m_clear();
    for (int a = 0; a < N; a++) for (int b = 0; b < N; b++) m_val[a][b] = 0;
    m_dup = 0;
  endfunction

  function automatic void m_write(input int a, input int b, input logic [31:0] v);
    if (m_val[a][b]) m_dup = 1;
    m_val[a][b] = 1;
    m_mem[a][b] = v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_count"}, count, m_count());
    chk({tag, "_complete"}, complete, m_count() == N*N);
    chk({tag, "_dup_err"}, dup_err, m_dup);
  endtask

  // Hold the strobe until ack is seen; exp_lat is cycles from raising stb to seeing ack.
  task automatic send(input int a, input int b, input logic [31:0] v, input int exp_lat);
    int lat;
    lat = 0;
    z_i = a[IW-1:0]; z_j = b[IW-1:0]; z_in = v; z_stb = 1;
    do begin tick(); lat++; end while (!z_ack && lat < 8);
    z_stb = 0;
    chk("ack_latency", lat, exp_lat);
    m_write(a, b, v);
    chk_status("send");
  endtask

  task automatic rd(input int a, input int b);
    rd_i = a[IW-1:0]; rd_j = b[IW-1:0]; rd_en = 1;
    tick();
    rd_en = 0;
    chk("rd_valid", rd_valid, 1);
    chk("rd_data", rd_data, m_mem[a][b]);
  endtask

  task automatic do_clear();
    clear = 1;
    tick();
    clear = 0;
    m_clear();
  endtask

  typedef struct {
    int          i, j;
    logic [31:0] d;
    int          cnt;
    bit          dup;
  } vec_t;

  initial begin
    vec_t tbl [4];
    int   acks, lat_next;
    tbl[0] = '{2, 1, 32'hAAAA0000, 1, 1'b0};
    tbl[1] = '{2, 1, 32'h00005555, 1, 1'b1};
    tbl[2] = '{3, 3, 32'h12345678, 2, 1'b1};
    tbl[3] = '{0, 2, 32'hCAFEF00D, 3, 1'b1};
    m_clear();

    // Reset state
    #12;
    chk("rst_z_ack", z_ack, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_count", count, 0);
    chk("rst_complete", complete, 0);
    chk("rst_dup_err", dup_err, 0);
    rst = 1;
    tick();

    // 16 unique writes, back to back: acks every 2 cycles, complete with the last
    for (int k = 0; k < 16; k++) send(k / 4, k % 4, 32'h3F800000 + k, (k == 0) ? 1 : 2);
    for (int k = 0; k < 16; k++) rd(k / 4, k % 4);

    // FULL: duplicate sets dup_err, then clear beats a simultaneous strobe
    send(1, 2, 32'hDEAD0001, 1);
    tick();
    z_i = 1; z_j = 3; z_in = 32'hBEEF0002; z_stb = 1; clear = 1;
    tick();
    clear = 0;
    m_clear();
    chk("clr_z_ack", z_ack, 0);
    chk_status("clr");
    send(1, 3, 32'hBEEF0002, 1);

    // Strobe held through the ack cycle yields exactly one ack
    tick();
    z_i = 3; z_j = 0; z_in = 32'h0BAD0003; z_stb = 1;
    acks = 0;
    tick(); acks += z_ack;
    tick(); acks += z_ack;
    z_stb = 0;
    tick(); acks += z_ack;
    tick(); acks += z_ack;
    chk("held_stb_acks", acks, 1);
    m_write(3, 0, 32'h0BAD0003);
    chk_status("held");

    // Table: duplicate handling after a clear
    do_clear();
    foreach (tbl[k]) begin
      send(tbl[k].i, tbl[k].j, tbl[k].d, (k == 0) ? 1 : 2);
      chk("tbl_count", count, tbl[k].cnt);
      chk("tbl_dup", dup_err, tbl[k].dup);
    end
    rd(2, 1);
    chk("tbl_rd21", rd_data, 32'h00005555);
    tick();
    chk("rd_valid_drop", rd_valid, 0);
    chk("rd_data_hold", rd_data, 32'h00005555);

    // Same-cycle read and write to (0,0): read sees the prior value
    send(0, 0, 32'hA0A0A0A0, 1);
    tick();
    z_i = 0; z_j = 0; z_in = 32'hB1B1B1B1; z_stb = 1;
    rd_i = 0; rd_j = 0; rd_en = 1;
    tick();
    z_stb = 0; rd_en = 0;
    chk("rw_ack", z_ack, 1);
    chk("rw_old_data", rd_data, 32'hA0A0A0A0);
    m_write(0, 0, 32'hB1B1B1B1);
    tick();
    rd(0, 0);
    chk_status("rw");

    // Random traffic against the model
    do_clear();
    lat_next = 1;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        rd($urandom_range(0, N-1), $urandom_range(0, N-1));
        lat_next = 1;
      end else begin
        send($urandom_range(0, N-1), $urandom_range(0, N-1), $urandom, lat_next);
        lat_next = 2;
      end
    end

    // Reset pulled while z_ack is high
    do_clear();
    send(0, 0, 32'h11110000, 1);
    send(0, 1, 32'h11110001, 2);
    send(0, 2, 32'h11110002, 2);
    chk("pre_rst_ack", z_ack, 1);
    #2 rst = 0;
    #1;
    chk("async_rst_ack", z_ack, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_complete", complete, 0);
    #1 rst = 1;
    m_clear();
    tick();
    for (int k = 0; k < 16; k++) send(k % 4, k / 4, 32'h40000000 + k, (k == 0) ? 1 : 2);
    chk("restream_complete", complete, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_result_collector.md
Name: matrix_result_collector

Overview:
Downstream consumer of the sequential matrix multiplier's result stream. Accepts (z_out, z_i, z_j) words over the z_stb/z_ack handshake and stores each into an N x N result buffer. Tracks which entries have arrived and asserts complete once all N*N are present. A registered random-access read port then supplies the stored matrix to the output writer stage.

Parameters:
N, 4, matrix dimension; buffer holds N*N words
DW, 32, data word width; contents are opaque and never interpreted
IW, max(1,clog2(N)), row/column index width

Ports:
clk  input  1  single clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset
clear  input  1  synchronous restart for the next matrix
z_in  input  DW  result word from the multiplier
z_i  input  IW  row index of z_in
z_j  input  IW  column index of z_in
z_stb  input  1  producer strobe; held high until z_ack is seen
z_ack  output  1  one-cycle acknowledge per accepted word
rd_en  input  1  read request
rd_i  input  IW  read row
rd_j  input  IW  read column
rd_data  output  DW  registered read data
rd_valid  output  1  high the cycle after an rd_en
count  output  clog2(N*N+1)  number of distinct entries written
complete  output  1  high while count == N*N
dup_err  output  1  sticky: duplicate or out-of-range index received

Behaviour:
- Reset (rst low, asynchronous): z_ack=0, rd_valid=0, rd_data=0, count=0, complete=0, dup_err=0, all valid bits=0, state=COLLECT. Buffer contents are not reset. If reset arrives mid-handshake, z_ack drops immediately.
- FSM states: COLLECT, ACK, FULL.
- COLLECT: if z_stb=1 and clear=0, write z_in to buf[z_i][z_j] and register z_ack=1. Next state is ACK.
- ACK: z_ack=1 for exactly this cycle. The stb that is still high here is not re-accepted. Next state is FULL if count==N*N, otherwise COLLECT.
- Latency: stb sampled in cycle t, z_ack high in cycle t+1, earliest next accept in cycle t+2. Sustained throughput is one word per 2 cycles.
- New index (valid bit clear): set the valid bit and increment count.
- Repeated index (valid bit set): overwrite the data, leave count unchanged, set dup_err.
- Out-of-range index (z_i>=N or z_j>=N, possible only when N is not a power of 2): no write, still acked, set dup_err.
- complete is asserted combinationally from count==N*N.
- FULL: strobes are still accepted and acked. Every one is a duplicate, so each overwrites and sets dup_err. The state stays FULL until clear or reset.
- clear=1: next edge zeroes count, valid bits and dup_err and moves to COLLECT. clear overrides an accept in the same cycle; that word is neither written nor acked and is picked up after clear deasserts. clear during ACK still lets that z_ack pulse complete.
- Read port: rd_en in cycle t gives rd_data=buf[rd_i][rd_j] and rd_valid=1 in cycle t+1. rd_data holds its value when rd_en=0.
- Same-cycle read and write to one address: the read returns the old value.
- Out-of-range read returns 0.
- Reads are legal in any state and never stall the write side.

Decomposition:
- Shared package matmul_pkg holds: DW, the index-width helper function, and the collector state enum (COLLECT/ACK/FULL) for reuse by the writer stage.
- One natural sub-module: entry_scoreboard.
  - Holds the N*N valid bits and the count register.
  - Inputs: set strobe, index, clear.
  - Outputs: already-set flag, count, complete.
- The buffer and FSM stay in the top module.

Test Plan:
- Reset, then 16 unique (i,j) writes with N=4 and values 0x3F800000+k → 16 z_ack pulses, each one cycle wide and 2 cycles apart. complete rises with the 16th ack, count=16, dup_err=0.
- Producer holds z_stb high through ack for one word → exactly one z_ack, count increments by 1, no double write.
- Write (2,1)=0xAAAA0000, then (2,1)=0x5555 again → count unchanged, dup_err=1, reading (2,1) gives 0x5555 one cycle after rd_en.
- In FULL, assert clear together with z_stb → no ack that cycle, count=0, complete=0, dup_err=0. The word is accepted in the following cycles.
- Pull rst low while z_ack=1 mid-stream → z_ack=0 and count=0 asynchronously. After release, a fresh 16-word stream completes normally.
- Read (0,0) in the same cycle as a write to (0,0) → rd_data shows the prior value. The next read shows the new value.
